// File: rtl/apb_pkg.sv
// Shared types and constants for the APB command master and its timeout counter.
package apb_pkg;

  localparam int APB_ADDR_W    = 8;
  localparam int APB_DATA_W    = 8;
  localparam int APB_TMO_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state counter for the APB ACCESS phase; flags the cycle in which the
// LIMIT-th consecutive PREADY=0 ACCESS cycle is being counted.
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [APB_TMO_CNT_W-1:0] LIMIT_M1 = APB_TMO_CNT_W'(LIMIT - 1);

  logic [APB_TMO_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The increment happening this cycle is the one that makes the count reach LIMIT.
  assign o_expired = i_en && (r_cnt == LIMIT_M1);

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB master: valid/ready command in, two-phase APB transfer,
// valid/ready response out. Define APB_CMD_TIMEOUT_EN to bound PREADY wait states.
//
// Handshakes: a transfer on req_* or rsp_* happens on a rising PCLK edge where
// both valid and ready are high; valid may not depend on ready, and the payload
// is held stable while valid is high and ready is low.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output apb_state_e        dbg_state
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT must be in 1..255");
  end

  apb_state_e        r_state;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              w_expired;

`ifdef APB_CMD_TIMEOUT_EN
  apb_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_timeout_cnt (
    .i_clk     (PCLK),
    .i_rst_n   (PRESETn),
    .i_clr     (r_state == SETUP),
    .i_en      ((r_state == ACCESS) && !PREADY),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_state  <= SETUP;
            r_psel   <= 1'b1;
            r_pwrite <= req_write;
            r_paddr  <= req_addr;
            r_pwdata <= req_write ? req_wdata : '0;
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
        end
        ACCESS: begin
          // A slave completing in the expiry cycle still gets its normal response.
          if (PREADY) begin
            r_state     <= RESP;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
            r_rsp_err   <= PSLVERR;
          end else if (w_expired) begin
            r_state     <= RESP;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign dbg_state = r_state;

endmodule
